hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage core. It sits beside the forwarding unit and sequences the F/D/E pipeline registers.
- Detects load-use and branch-operand hazards, which forwarding cannot resolve, and produces stall and flush controls.
- Owns the start/busy/done sequencing of the multi-cycle multiply/divide unit (MDU) and stalls HI/LO consumers until the result is ready.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_detect.sv | 37 +++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MDU sequencer state encoding and default
// multiply/divide latencies, common to the hazard controller and the MDU.
package pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the controller, stall/flush
// and MDU sequencing back out. The pipeline side is master, the controller slave.
interface hazard_ctrl_if;

  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] r3_addrE;
  logic [4:0] r3_addrM;
  logic       RegWriteE;
  logic       MemtoRegE;
  logic       MemtoRegM;
  logic       BranchD;
  logic       BranchTakenD;
  logic       MduStartE;
  logic       MduIsDivE;
  logic       HiLoUseD;
  logic       stallF;
  logic       stallD;
  logic       flushD;
  logic       flushE;
  logic       mdu_start;
  logic       mdu_busy;
  logic       mdu_done;

  modport master (
    output rsD, rtD, r3_addrE, r3_addrM, RegWriteE, MemtoRegE, MemtoRegM,
           BranchD, BranchTakenD, MduStartE, MduIsDivE, HiLoUseD,
    input  stallF, stallD, flushD, flushE, mdu_start, mdu_busy, mdu_done
  );

  modport slave (
    input  rsD, rtD, r3_addrE, r3_addrM, RegWriteE, MemtoRegE, MemtoRegM,
           BranchD, BranchTakenD, MduStartE, MduIsDivE, HiLoUseD,
    output stallF, stallD, flushD, flushE, mdu_start, mdu_busy, mdu_done
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard detection: load-use, branch-operand and HI/LO
// consumer hazards that the forwarding network cannot cover.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  r3_addrE,
  input  logic [4:0]  r3_addrM,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        HiLoUseD,
  input  logic        MduStartE,
  input  mdu_state_e  state,
  input  logic        cnt_nz,
  output logic        lwstall,
  output logic        brstall,
  output logic        hlstall
);

  logic match_e;
  logic match_m;

  // Register $0 is never a real dependency, so a zero address never matches.
  always_comb begin
    match_e = (r3_addrE != 5'd0) && ((r3_addrE == rsD) || (r3_addrE == rtD));
    match_m = (r3_addrM != 5'd0) && ((r3_addrM == rsD) || (r3_addrM == rtD));
    lwstall = MemtoRegE && RegWriteE && match_e;
    // ALU results in M are forwarded into D, only a load in M must wait.
    brstall = BranchD && ((RegWriteE && match_e) || (MemtoRegM && match_m));
    hlstall = HiLoUseD && (((state == IDLE) && MduStartE) ||
                           ((state == BUSY) && cnt_nz));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation for F/D/E and the
// start/busy/done sequencer of the multi-cycle multiply/divide unit.
// Optional build macro HAZARD_PERF_EN adds saturating stall and MDU-busy
// cycle counters as extra outputs.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_mdu_cnt
`endif
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_nz;
  logic             lwstall;
  logic             brstall;
  logic             hlstall;
  logic             stall;
  logic             busy;

  assign cnt_nz = |cnt;

  hazard_detect u_detect (
    .rsD       (bus.rsD),
    .rtD       (bus.rtD),
    .r3_addrE  (bus.r3_addrE),
    .r3_addrM  (bus.r3_addrM),
    .RegWriteE (bus.RegWriteE),
    .MemtoRegE (bus.MemtoRegE),
    .MemtoRegM (bus.MemtoRegM),
    .BranchD   (bus.BranchD),
    .HiLoUseD  (bus.HiLoUseD),
    .MduStartE (bus.MduStartE),
    .state     (state),
    .cnt_nz    (cnt_nz),
    .lwstall   (lwstall),
    .brstall   (brstall),
    .hlstall   (hlstall)
  );

  // Outputs are forced low while reset is held, whatever the pipeline shows.
  always_comb begin
    stall          = rst_n && (lwstall || brstall || hlstall);
    busy           = rst_n && (state == BUSY);
    bus.stallF     = stall;
    bus.stallD     = stall;
    bus.flushE     = stall;
    // A stalled branch keeps its slot in D; flush only once it moves on.
    bus.flushD     = rst_n && bus.BranchTakenD && !stall;
    bus.mdu_start  = rst_n && (state == IDLE) && bus.MduStartE;
    bus.mdu_busy   = busy;
    bus.mdu_done   = busy && !cnt_nz;
  end

  // MDU sequencer: load latency-1 on start, count down, finish when zero.
  // A start seen while BUSY is ignored (no reload).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MduStartE) begin
            cnt   <= bus.MduIsDivE ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_nz) cnt <= cnt - 1'b1;
          else        state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counters of stalled cycles and MDU busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_mdu_cnt   <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (busy && (perf_mdu_cnt != '1))    perf_mdu_cnt   <= perf_mdu_cnt + 1'b1;
    end
  end
`endif

endmodule
